homomorphic_add_ctrl: RTL
=========================

Name: homomorphic_add_ctrl

Overview:
Sequences a full-ciphertext homomorphic addition through the PARALLEL-lane adder datapath. On a start pulse it streams both source ciphertexts (DIMENSION+1 words each) out of ciphertext memory in PARALLEL-word beats and drives the adder enable. It then writes each sum beat back to a destination buffer. The controller carries only addresses and control; read data flows memory -> adder -> memory without passing through it.

Parameters:
CIPHERTEXT_WIDTH, 10, word width; sums wrap modulo 2^CIPHERTEXT_WIDTH, which is the ciphertext modulus (1024).
DIMENSION, 1, LWE dimension; each ciphertext is DIMENSION+1 words.
PARALLEL, 1, adder lanes, i.e. words per beat.
ADDR_WIDTH, 8, beat-address width of the ciphertext memories.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle request; sampled only in IDLE
src1_base  in  ADDR_WIDTH  beat address of ciphertext 1; captured at accepted start
src2_base  in  ADDR_WIDTH  beat address of ciphertext 2; captured at accepted start
dst_base  in  ADDR_WIDTH  beat address of the result; captured at accepted start
busy  out  1  operation in progress
done  out  1  one-cycle pulse, coincident with the last write
rd_en  out  1  read strobe to both source memories
rd_addr1  out  ADDR_WIDTH  source-1 read address
rd_addr2  out  ADDR_WIDTH  source-2 read address
add_en  out  1  adder enable
wr_en  out  1  destination write strobe
wr_addr  out  ADDR_WIDTH  destination write address
wr_mask  out  PARALLEL  per-lane write enables

Behaviour:
- Constants: NB = ceil((DIMENSION+1)/PARALLEL) beats. LAST_LANES = (DIMENSION+1) - (NB-1)*PARALLEL.
- External latencies are fixed: memory read data is valid 1 cycle after rd_en; adder output is valid 1 cycle after add_en. There is no backpressure.
- States and transitions:
  - IDLE -> READ on start. The three base addresses are captured and the beat counter k is cleared.
  - READ: rd_en=1; rd_addr1 = src1_base+k, rd_addr2 = src2_base+k. k increments every cycle. After beat NB-1 is issued, go to DRAIN.
  - DRAIN: wait until the last write issues, then go to IDLE.
- Pipeline alignment:
  - add_en equals rd_en delayed 1 cycle.
  - wr_en equals rd_en delayed 2 cycles.
  - wr_addr = dst_base + (beat index delayed 2 cycles).
  - wr_mask = all ones, except on beat NB-1, where bits [LAST_LANES-1:0] are set and the rest are clear.
- Timing, with start accepted at edge 0:
  - rd_en is high in cycles 1..NB, add_en in 2..NB+1, wr_en in 3..NB+2.
  - done is high in cycle NB+2 only.
  - busy is high in cycles 1..NB+2 and low from NB+3.
  - Total latency is NB+2 cycles; the next start is accepted in cycle NB+3.
- start while busy (including the done cycle) is ignored, not queued.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap past the top of memory is silent and legal.
- When add_en is low the adder clears its register to 0. The controller must keep add_en low outside beats so stale sums are never written.
- Reset (also mid-operation), effective next cycle:
  - state -> IDLE, k = 0, delay pipeline flushed.
  - busy, done, rd_en, add_en, wr_en, wr_mask, all addresses = 0.
  - No done is emitted for an aborted operation, and no pending write survives reset.
- NB=1 (DIMENSION+1 <= PARALLEL) is legal: READ lasts one cycle and done is in cycle 3.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, READ, DRAIN);
  - the functions computing NB and LAST_LANES;
  - the ciphertext word typedef logic [CIPHERTEXT_WIDTH-1:0].
- One natural sub-module: ctrl_delay_line, a 2-stage shift register carrying {valid, beat index, last flag}. It derives add_en (tap 1), and wr_en/wr_addr/wr_mask/done (tap 2).

Test Plan:
- PARALLEL=1, DIMENSION=1 (NB=2); start with src1=0x10, src2=0x20, dst=0x30 -> rd_addr 0x10/0x20 then 0x11/0x21 in cycles 1-2. wr_en in cycles 3-4 at 0x30, 0x31, mask 1. done in cycle 4, busy low in cycle 5. Memory model check, lane 0: 700+500 stores 176.
- PARALLEL=4, DIMENSION=9 (NB=3, LAST_LANES=2) -> wr_mask 4'b1111, 4'b1111, 4'b0011. done in cycle 5.
- start pulsed in cycles 2 and 4 of a running operation -> ignored; exactly one done. A start in the first IDLE cycle is accepted.
- rst asserted in cycle 2 (mid-READ) -> next cycle all outputs 0, no wr_en or done afterwards. A following start runs cleanly from beat 0.
- PARALLEL=4, DIMENSION=3 (NB=1) -> rd_en cycle 1, add_en cycle 2, wr_en+done cycle 3, mask 4'b1111.
- src1_base=0xFF, NB=2 -> rd_addr1 0xFF then 0x00 (wrap).

Source files
------------

// File: rtl/homomorphic_add_ctrl_pkg.sv
// Shared types and sizing helpers for the homomorphic ciphertext-add controller.
package homomorphic_add_ctrl_pkg;

   localparam int CT_WIDTH = 10;

   typedef logic [CT_WIDTH-1:0] ct_word_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } state_t;

   // Beats needed to move one ciphertext of dimension+1 words, rounded up.
   function automatic int calc_nb(input int dimension, input int parallel);
      return (dimension + parallel) / parallel;
   endfunction

   function automatic int calc_last_lanes(input int dimension, input int parallel);
      return (dimension + 1) - (calc_nb(dimension, parallel) - 1) * parallel;
   endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Two-stage pipeline carrying {valid, beat, last}; stage 1 enables the adder,
// stage 2 drives the destination write and the completion pulse.
module ctrl_delay_line #(
   parameter int ADDR_WIDTH = 8,
   parameter int PARALLEL   = 1,
   parameter int LAST_LANES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_beat,
   input  logic                  issue_last,
   input  logic [ADDR_WIDTH-1:0] dst_base,
   output logic                  add_en,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [PARALLEL-1:0]   wr_mask,
   output logic                  done
);

   logic                  valid1_reg;
   logic                  last1_reg;
   logic [ADDR_WIDTH-1:0] beat1_reg;
   logic                  wr_en_reg;
   logic                  done_reg;
   logic [ADDR_WIDTH-1:0] wr_addr_reg;
   logic [PARALLEL-1:0]   wr_mask_reg;
   logic [PARALLEL-1:0]   last_mask;

   genvar gi;
   generate
      for (gi = 0; gi < PARALLEL; gi++) begin : g_last_mask
         assign last_mask[gi] = (gi < LAST_LANES);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         valid1_reg  <= 1'b0;
         last1_reg   <= 1'b0;
         beat1_reg   <= '0;
         wr_en_reg   <= 1'b0;
         done_reg    <= 1'b0;
         wr_addr_reg <= '0;
         wr_mask_reg <= '0;
      end else begin
         valid1_reg  <= issue_valid;
         last1_reg   <= issue_valid && issue_last;
         beat1_reg   <= issue_valid ? issue_beat : '0;
         wr_en_reg   <= valid1_reg;
         done_reg    <= valid1_reg && last1_reg;
         // Idle stages emit zero address and mask so nothing stale reaches memory.
         wr_addr_reg <= valid1_reg ? dst_base + beat1_reg : '0;
         wr_mask_reg <= !valid1_reg ? '0 : (last1_reg ? last_mask : '1);
      end
   end

   assign add_en  = valid1_reg;
   assign wr_en   = wr_en_reg;
   assign wr_addr = wr_addr_reg;
   assign wr_mask = wr_mask_reg;
   assign done    = done_reg;

endmodule

// File: rtl/homomorphic_add_ctrl.sv
// Sequences a full-ciphertext add: streams both sources out of memory beat by
// beat, enables the lane adder, and writes the sums back to the destination.
module homomorphic_add_ctrl
   import homomorphic_add_ctrl_pkg::*;
#(
   parameter int CIPHERTEXT_WIDTH = 10,
   parameter int DIMENSION        = 1,
   parameter int PARALLEL         = 1,
   parameter int ADDR_WIDTH       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src1_base,
   input  logic [ADDR_WIDTH-1:0] src2_base,
   input  logic [ADDR_WIDTH-1:0] dst_base,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr1,
   output logic [ADDR_WIDTH-1:0] rd_addr2,
   output logic                  add_en,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [PARALLEL-1:0]   wr_mask
);

   localparam int NB         = calc_nb(DIMENSION, PARALLEL);
   localparam int LAST_LANES = calc_last_lanes(DIMENSION, PARALLEL);
   localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(NB - 1);

   generate
      if (CIPHERTEXT_WIDTH < 1 || DIMENSION < 1 || PARALLEL < 1 || ADDR_WIDTH < 1) begin : g_param_check
         $error("homomorphic_add_ctrl: widths, DIMENSION and PARALLEL must be positive");
      end
   endgenerate

   state_t                state_reg;
   logic [ADDR_WIDTH-1:0] k_reg;
   logic [ADDR_WIDTH-1:0] k_next;
   logic [ADDR_WIDTH-1:0] src1_reg;
   logic [ADDR_WIDTH-1:0] src2_reg;
   logic [ADDR_WIDTH-1:0] dst_reg;
   logic                  busy_reg;
   logic                  rd_en_reg;
   logic [ADDR_WIDTH-1:0] rd_addr1_reg;
   logic [ADDR_WIDTH-1:0] rd_addr2_reg;
   logic                  issue_last;

   assign k_next     = k_reg + ADDR_WIDTH'(1);
   assign issue_last = (k_reg == LAST_BEAT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         k_reg        <= '0;
         src1_reg     <= '0;
         src2_reg     <= '0;
         dst_reg      <= '0;
         busy_reg     <= 1'b0;
         rd_en_reg    <= 1'b0;
         rd_addr1_reg <= '0;
         rd_addr2_reg <= '0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg    <= READ;
                  k_reg        <= '0;
                  src1_reg     <= src1_base;
                  src2_reg     <= src2_base;
                  dst_reg      <= dst_base;
                  busy_reg     <= 1'b1;
                  rd_en_reg    <= 1'b1;
                  rd_addr1_reg <= src1_base;
                  rd_addr2_reg <= src2_base;
               end
            end
            READ: begin
               // Registers hold the beat being issued now; advance or finish.
               if (issue_last) begin
                  state_reg    <= DRAIN;
                  k_reg        <= '0;
                  rd_en_reg    <= 1'b0;
                  rd_addr1_reg <= '0;
                  rd_addr2_reg <= '0;
               end else begin
                  k_reg        <= k_next;
                  rd_addr1_reg <= src1_reg + k_next;
                  rd_addr2_reg <= src2_reg + k_next;
               end
            end
            DRAIN: begin
               if (done) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   ctrl_delay_line #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .PARALLEL   (PARALLEL),
      .LAST_LANES (LAST_LANES)
   ) u_delay_line (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (rd_en_reg),
      .issue_beat  (k_reg),
      .issue_last  (issue_last),
      .dst_base    (dst_reg),
      .add_en      (add_en),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_mask     (wr_mask),
      .done        (done)
   );

   assign busy     = busy_reg;
   assign rd_en    = rd_en_reg;
   assign rd_addr1 = rd_addr1_reg;
   assign rd_addr2 = rd_addr2_reg;

endmodule
